// File: rtl/timer_multi_ch.sv
// Multi-channel up-counting timer with a shared tick prescaler, one-shot or periodic per channel.
// Define TIMER_IRQ_STICKY_EN to make out_int sticky until int_clr; otherwise out_int is a one-cycle pulse.
//
// state | meaning
// IDLE  | channel stopped, cnt holds last value (dur after one-shot expiry, 0 after reset/zero load)
// RUN   | counting up by one per prescaler tick
// PAUSE | stop_sig held, cnt frozen
module timer_multi_ch #(
    parameter int WIDTH      = 8,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] time_dur,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       stop_sig,
    input  logic [PRESCALE_W-1:0]     prescale,
    input  logic [CHANNELS-1:0]       int_clr,
    output logic [CHANNELS*WIDTH-1:0] cnt,
    output logic [CHANNELS-1:0]       out_int,
    output logic [CHANNELS-1:0]       busy,
    output logic                      irq
);

`ifdef TIMER_IRQ_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  tick;

    assign tick = (pre_cnt == prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] dur_q;
        logic [WIDTH-1:0] dur_in;
        logic [WIDTH-1:0] cnt_inc;
        logic             mode_q;
        logic             int_q;
        logic             busy_q;

        assign dur_in  = time_dur[k*WIDTH +: WIDTH];
        assign cnt_inc = cnt_q + 1'b1;

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= IDLE;
                cnt_q  <= '0;
                dur_q  <= '0;
                mode_q <= 1'b0;
                int_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                // A new expiry below overrides a same-cycle clear.
                int_q <= STICKY & int_q & ~int_clr[k];
                if (load[k]) begin
                    cnt_q <= '0;
                    if (dur_in != '0) begin
                        state  <= RUN;
                        busy_q <= 1'b1;
                        dur_q  <= dur_in;
                        mode_q <= mode[k];
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end else begin
                    case (state)
                        RUN: begin
                            if (stop_sig[k]) begin
                                state <= PAUSE;
                            end else if (tick) begin
                                if (cnt_q == dur_q) begin
                                    cnt_q <= '0;
                                end else begin
                                    cnt_q <= cnt_inc;
                                    if (cnt_inc == dur_q) begin
                                        int_q <= 1'b1;
                                        if (!mode_q) begin
                                            state  <= IDLE;
                                            busy_q <= 1'b0;
                                        end
                                    end
                                end
                            end
                        end
                        // The release edge only re-enters RUN; counting picks up on the next tick.
                        PAUSE: begin
                            if (!stop_sig[k]) begin
                                state <= RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign cnt[k*WIDTH +: WIDTH] = cnt_q;
        assign out_int[k]            = int_q;
        assign busy[k]               = busy_q;
    end

    assign irq = |out_int;

endmodule

// File: tb/tb_timer_multi_ch.sv
// Scoreboard bench for timer_multi_ch (WIDTH=4, CHANNELS=2, PRESCALE_W=4): directed scenarios
// followed by random stimulus, checked against a behavioural per-channel model.
module tb_timer_multi_ch;

`ifdef TIMER_IRQ_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] load;
    logic [7:0] time_dur;
    logic [1:0] mode;
    logic [1:0] stop_sig;
    logic [3:0] prescale;
    logic [1:0] int_clr;
    logic [7:0] cnt;
    logic [1:0] out_int;
    logic [1:0] busy;
    logic       irq;

    timer_multi_ch #(.WIDTH(4), .CHANNELS(2), .PRESCALE_W(4)) dut (
        .clk(clk), .rst(rst), .load(load), .time_dur(time_dur), .mode(mode),
        .stop_sig(stop_sig), .prescale(prescale), .int_clr(int_clr),
        .cnt(cnt), .out_int(out_int), .busy(busy), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cnt;
        logic [1:0] oi;
        logic [1:0] busy;
        logic       irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: a channel is "running" or not, and a running channel may be "paused".
    int m_pre;
    int m_cnt[2];
    int m_dur[2];
    bit m_run[2];
    bit m_pause[2];
    bit m_per[2];
    bit m_int[2];

    task automatic model_step();
        bit   tick;
        bit   fire;
        int   d;
        exp_t e;
        tick = (m_pre == int'(prescale));
        for (int k = 0; k < 2; k++) begin
            fire = 1'b0;
            d    = int'(time_dur[k*4 +: 4]);
            if (rst) begin
                m_run[k] = 0; m_pause[k] = 0; m_cnt[k] = 0; m_dur[k] = 0; m_per[k] = 0; m_int[k] = 0;
                continue;
            end
            if (load[k]) begin
                m_cnt[k]   = 0;
                m_pause[k] = 0;
                m_run[k]   = (d != 0);
                if (d != 0) begin
                    m_dur[k] = d;
                    m_per[k] = mode[k];
                end
            end else if (m_run[k] && m_pause[k]) begin
                if (!stop_sig[k]) m_pause[k] = 0;
            end else if (m_run[k]) begin
                if (stop_sig[k]) m_pause[k] = 1;
                else if (tick) begin
                    if (m_cnt[k] == m_dur[k]) m_cnt[k] = 0;
                    else begin
                        m_cnt[k] = m_cnt[k] + 1;
                        if (m_cnt[k] == m_dur[k]) begin
                            fire = 1'b1;
                            if (!m_per[k]) m_run[k] = 0;
                        end
                    end
                end
            end
            m_int[k] = fire | (STICKY & m_int[k] & ~int_clr[k]);
        end
        m_pre = (rst || tick) ? 0 : (m_pre + 1) % 16;
        e.cnt  = {4'(m_cnt[1]), 4'(m_cnt[0])};
        e.oi   = {m_int[1], m_int[0]};
        e.busy = {m_run[1], m_run[0]};
        e.irq  = m_int[0] | m_int[1];
        exp_q.push_back(e);
    endtask

    // Drive the current stimulus for one cycle, then drop the strobes.
    task automatic step();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
        load    = '0;
        int_clr = '0;
        rst     = 1'b0;
    endtask

    task automatic load_ch(input int k, input int d, input bit per);
        load[k]           = 1'b1;
        time_dur[k*4 +: 4] = 4'(d);
        mode[k]           = per;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: one expected entry per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks += 4;
                if (cnt !== e.cnt) begin
                    failures++;
                    $display("FAIL cnt t=%0t got=%h exp=%h", $time, cnt, e.cnt);
                end
                if (out_int !== e.oi) begin
                    failures++;
                    $display("FAIL out_int t=%0t got=%b exp=%b", $time, out_int, e.oi);
                end
                if (busy !== e.busy) begin
                    failures++;
                    $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e.busy);
                end
                if (irq !== e.irq) begin
                    failures++;
                    $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, e.irq);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load = '0; time_dur = '0; mode = '0; stop_sig = '0; prescale = '0; int_clr = '0;
        m_pre = 0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_dur[k] = 0; m_run[k] = 0; m_pause[k] = 0; m_per[k] = 0; m_int[k] = 0;
        end
        rst = 1'b1; step();
        rst = 1'b1; step();

        // One-shot dur=3, tick every cycle.
        load_ch(0, 3, 1'b0);
        idle(6);

        // Periodic dur=2 on ch1, then stopped with a zero load.
        load_ch(1, 2, 1'b1);
        idle(10);
        load_ch(1, 0, 1'b0);

        // Pause at cnt0=2 with prescale=1.
        prescale = 4'd1;
        load_ch(0, 5, 1'b0);
        for (int i = 0; i < 20 && m_cnt[0] != 2; i++) step();
        stop_sig[0] = 1'b1;
        idle(6);
        stop_sig[0] = 1'b0;
        idle(12);

        // Reload mid-count, then zero-duration load.
        prescale = 4'd0;
        load_ch(0, 9, 1'b0);
        idle(4);
        load_ch(0, 5, 1'b0);
        idle(7);
        load_ch(0, 9, 1'b0);
        idle(3);
        load_ch(0, 0, 1'b0);
        idle(4);

        // Reset while both channels run (one paused).
        load_ch(0, 7, 1'b1);
        load_ch(1, 6, 1'b0);
        idle(2);
        stop_sig[1] = 1'b1;
        idle(2);
        rst = 1'b1; step();
        stop_sig[1] = 1'b0;
        idle(4);

        // Interrupt clear three cycles after expiry.
        load_ch(0, 2, 1'b0);
        for (int i = 0; i < 10 && !m_int[0]; i++) step();
        idle(2);
        int_clr[0] = 1'b1; step();
        idle(3);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 15) == 0) begin
                    load[k]            = 1'b1;
                    time_dur[k*4 +: 4] = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                    mode[k]            = 1'($urandom);
                end else if ($urandom_range(0, 3) == 0) begin
                    time_dur[k*4 +: 4] = 4'($urandom);
                    mode[k]            = 1'($urandom);
                end
                if ($urandom_range(0, 7) == 0) stop_sig[k] = ~stop_sig[k];
                if ($urandom_range(0, 7) == 0) int_clr[k] = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) prescale = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 199) == 0) rst = 1'b1;
            step();
        end

        load = '0; stop_sig = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
